serial_pattern_fsm: RTL and testbench
=====================================

Name: serial_pattern_fsm

Overview:
- Parametrised Moore serial pattern detector. It generalises the fixed six-state w/z detector to a runtime-programmable pattern of up to PAT_W bits.
- Supports overlapping and non-overlapping match modes and a valid qualifier on the serial input.
- Sits on single-bit serial control/status lines; z feeds downstream event logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (2..16).
- DEF_PATTERN, 8'b0000_1101, pattern loaded at reset; bit 0 is compared first.
- DEF_LEN, 4, pattern length loaded at reset (1..PAT_W).
- DEF_OVERLAP, 1, overlap mode loaded at reset.
- CNT_W, 8, width of match_cnt.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- w  in  1  serial data bit.
- w_valid  in  1  w is sampled only when 1.
- cfg_load  in  1  load new cfg_pattern, cfg_len and cfg_overlap this cycle.
- cfg_pattern  in  PAT_W  pattern; bit i is the i-th bit expected.
- cfg_len  in  $clog2(PAT_W+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- z  out  1  Moore output: 1 while state == len.
- match_cnt  out  CNT_W  saturating match count (optional feature).

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). All registers update on posedge clk.
- State is match progress p, range 0..len; p = number of pattern bits currently matched.
- Reset: p=0, pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, z=0, match_cnt=0. Reset has priority over cfg_load and w_valid.
- cfg_load=1 (no reset):
  - pattern, len and overlap registers take the cfg_* values; p returns to 0.
  - w is ignored that cycle, even if w_valid=1.
  - cfg_len of 0 is stored as 1; a value above PAT_W is stored as PAT_W.
  - Bits of cfg_pattern at index >= len are don't-care.
- w_valid=0: p holds and z holds.
- w_valid=1, normal step:
  - Base state b = p, except that b = 0 when p==len and overlap==0.
  - Next p = largest k <= min(b+1, len) such that the last k bits of (matched prefix of length b, then w) equal pattern[k-1:0]. This is the KMP fallback.
  - Progress is never lost beyond the longest valid suffix.
- z = (p == len). It is a registered Moore output with no combinational path from w.
  - Latency: z rises in the cycle after the edge that samples the final pattern bit.
  - z stays 1 through any w_valid=0 stall while in the match state.
- Overlap=1 from p==len: fallback to the longest proper border of the pattern, so back-to-back matches can assert z on consecutive valid cycles.
- Pattern of all ones with overlap=1: z stays high on every valid 1 after the first len ones.
- len==1: p toggles between 0 and 1; z = last valid w equal to pattern[0].
- Next-state logic is purely combinational over the registered pattern, with a loop bounded by PAT_W. An unreachable p > len recovers to p=0.

Optional Feature:
- Macro: SERIAL_PATTERN_MATCH_CNT_EN.
- Defined:
  - match_cnt increments by 1 on every valid step whose next p == len. This includes consecutive overlapping matches.
  - It saturates at 2^CNT_W-1.
  - It is cleared by reset and by cfg_load.
- Undefined: match_cnt is driven constant 0 and no counter flops exist.

Decomposition:
- Package serial_pattern_pkg holds:
  - PAT_W_MAX=16;
  - the function len_w(PAT_W) = $clog2(PAT_W+1);
  - the typedef for the progress state;
  - the cfg_len clamp function.
- Sub-module serial_pattern_next: combinational. Inputs are pattern, len, b and w; output is next p. It is the KMP fallback search and is reusable by multi-lane variants.

Test Plan:
- Reset defaults (pattern 1,0,1,1, overlap=1). Drive w=1,0,1,1,0,1,1 all valid → z=1 in the cycle after the 4th bit and after the 7th bit only; match_cnt=2.
- cfg_load with pattern 4'b1101, len=4, overlap=0. Then w=1,0,1,1,0,1,1 → z=1 once (after 4th bit); p after the 7th bit is 1; match_cnt=1.
- Stall: reach the match state, then hold w_valid=0 for 5 cycles with w toggling → z stays 1 and p is unchanged. The next valid w=0 gives p=2 and z=0.
- Clamping: cfg_len=0 with pattern bit0=1, then w=1 → z=1 next cycle. Separately, cfg_len=15 with PAT_W=8 → len reads back as 8, and 8 matching bits assert z.
- Mid-operation: at p=3, assert reset with w_valid=1 → next cycle p=0, z=0, default pattern restored. Repeat with cfg_load instead → p=0 and the w that cycle is ignored.
- Saturation (macro defined, CNT_W=2): pattern len=1 with pattern[0]=1, w=1 for 6 valid cycles → match_cnt reads 1,2,3,3,3,3.

Source files
------------

// File: rtl/serial_pattern_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package serial_pattern_pkg;

  localparam int PAT_W_MAX = 16;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Progress p ranges 0..PAT_W_MAX, so it needs one bit more than an index.
  typedef logic [$clog2(PAT_W_MAX + 1)-1:0] prog_t;

  typedef enum logic {
    MATCH_NONOVL = 1'b0,
    MATCH_OVL    = 1'b1
  } ovl_mode_t;

  function automatic prog_t clamp_len(input prog_t raw, input int pat_w);
    if (raw == '0) return prog_t'(1);
    if (int'(raw) > pat_w) return prog_t'(pat_w);
    return raw;
  endfunction

endpackage

// File: rtl/serial_pattern_next.sv
// KMP fallback search: the longest pattern prefix that is a suffix of
// (pattern[b-1:0] followed by w), capped at len.
module serial_pattern_next
  import serial_pattern_pkg::*;
#(
  parameter int PAT_W = 8
) (
  input  logic [PAT_W-1:0] pattern,
  input  prog_t            len,
  input  prog_t            b,
  input  logic             w,
  output prog_t            nxt
);

  always_comb begin
    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] tail;
    logic [PAT_W-1:0] pk;
    int               sh;
    mask = '0;
    tail = '0;
    pk   = '0;
    sh   = 0;
    nxt  = '0;
    // Ascending k, so the last hit is the longest valid suffix.
    for (int k = 1; k <= PAT_W; k++) begin
      sh   = (k <= int'(b) + 1) ? (int'(b) + 1 - k) : 0;
      mask = {PAT_W{1'b1}} >> (PAT_W - k + 1);
      tail = pattern >> sh;
      pk   = pattern >> (k - 1);
      if ((k <= int'(b) + 1) && (k <= int'(len)) && (pk[0] == w) &&
          ((tail & mask) == (pattern & mask)))
        nxt = prog_t'(k);
    end
  end

endmodule

// File: rtl/serial_pattern_fsm.sv
// Runtime-programmable Moore serial pattern detector with overlap control.
// Optional saturating match counter enabled by SERIAL_PATTERN_MATCH_CNT_EN.
module serial_pattern_fsm
  import serial_pattern_pkg::*;
#(
  parameter int               PAT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 8'b0000_1101,
  parameter int               DEF_LEN     = 4,
  parameter bit               DEF_OVERLAP = 1'b1,
  parameter int               CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w,
  input  logic                      w_valid,
  input  logic                      cfg_load,
  input  logic [PAT_W-1:0]          cfg_pattern,
  input  logic [len_w(PAT_W)-1:0]   cfg_len,
  input  logic                      cfg_overlap,
  output logic                      z,
  output logic [CNT_W-1:0]          match_cnt
);

  prog_t            p;
  prog_t            len_r;
  logic [PAT_W-1:0] pattern_r;
  ovl_mode_t        mode_r;
  prog_t            base;
  prog_t            p_kmp;
  prog_t            p_nxt;
  prog_t            len_cfg;

  assign len_cfg = clamp_len(prog_t'(cfg_len), PAT_W);

  // A completed match restarts from scratch unless overlapping is allowed.
  assign base  = (p == len_r && mode_r == MATCH_NONOVL) ? '0 : p;
  assign p_nxt = (p > len_r) ? '0 : p_kmp;

  serial_pattern_next #(
    .PAT_W(PAT_W)
  ) u_next (
    .pattern(pattern_r),
    .len    (len_r),
    .b      (base),
    .w      (w),
    .nxt    (p_kmp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      p         <= '0;
      pattern_r <= DEF_PATTERN;
      len_r     <= clamp_len(prog_t'(DEF_LEN), PAT_W);
      mode_r    <= DEF_OVERLAP ? MATCH_OVL : MATCH_NONOVL;
      z         <= 1'b0;
    end else if (cfg_load) begin
      p         <= '0;
      pattern_r <= cfg_pattern;
      len_r     <= len_cfg;
      mode_r    <= cfg_overlap ? MATCH_OVL : MATCH_NONOVL;
      z         <= 1'b0;
    end else if (w_valid) begin
      p         <= p_nxt;
      z         <= (p_nxt == len_r);
    end
  end

`ifdef SERIAL_PATTERN_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  always_ff @(posedge clk) begin
    if (reset || cfg_load)
      cnt_r <= '0;
    else if (w_valid && p_nxt == len_r && cnt_r != {CNT_W{1'b1}})
      cnt_r <= cnt_r + CNT_W'(1);
  end

  assign match_cnt = cnt_r;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_serial_pattern_fsm.sv
// Directed bench for serial_pattern_fsm with a history-based reference model.
module tb_serial_pattern_fsm;
  import serial_pattern_pkg::*;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LW    = len_w(PAT_W);
`ifdef SERIAL_PATTERN_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             w;
  logic             w_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LW-1:0]    cfg_len;
  logic             cfg_overlap;
  logic             z;
  logic [CNT_W-1:0] match_cnt;

  always #5 clk = ~clk;

  serial_pattern_fsm #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .w          (w),
    .w_valid    (w_valid),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .z          (z),
    .match_cnt  (match_cnt)
  );

  typedef struct {
    logic  z;
    int    cnt;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: z is "the last len valid bits equal the pattern",
  // with history discarded after a match in non-overlapping mode.
  bit [PAT_W-1:0] m_pat;
  int             m_len;
  bit             m_ovl;
  bit             hist[$];
  logic           m_z;
  int             m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_step(input bit rst, input bit load, input bit valid, input bit wb);
    bit hit;
    if (rst) begin
      m_pat = 8'b0000_1101; m_len = 4; m_ovl = 1'b1;
      hist.delete(); m_z = 1'b0; m_cnt = 0;
    end else if (load) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len));
      m_ovl = cfg_overlap;
      hist.delete(); m_z = 1'b0; m_cnt = 0;
    end else if (valid) begin
      hist.push_back(wb);
      if (hist.size() > 16) void'(hist.pop_front());
      hit = (hist.size() >= m_len);
      for (int j = 0; j < m_len; j++)
        if (hit && hist[hist.size() - m_len + j] != m_pat[j]) hit = 1'b0;
      m_z = hit;
      if (hit) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_ovl) hist.delete();
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit load, input bit valid, input bit wb,
                       input string tag);
    exp_t e;
    reset = rst; cfg_load = load; w_valid = valid; w = wb;
    model_step(rst, load, valid, wb);
    e.z = m_z; e.cnt = CNT_ON ? m_cnt : 0; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".z"}, 32'(z), 32'(e.z));
    check({e.tag, ".cnt"}, 32'(match_cnt), 32'(e.cnt));
  endtask

  task automatic feed(input bit [15:0] bits, input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, bits[i], tag);
  endtask

  initial begin
    reset = 1'b1; w = 1'b0; w_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    @(negedge clk);

    // Defaults, overlapping: 1,0,1,1,0,1,1 matches after bits 4 and 7
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    check("reset.p", 32'(dut.p), 32'd0);
    check("reset.len", 32'(dut.len_r), 32'd4);
    check("reset.pat", 32'(dut.pattern_r), 32'h0D);
    feed(16'b0110_1101, 7, "ovl_seq");
    check("ovl_seq.final_cnt", 32'(match_cnt), CNT_ON ? 32'd2 : 32'd0);

    // Non-overlapping: one match, p=1 after bit 7
    cfg_pattern = 8'b0000_1101; cfg_len = 4'd4; cfg_overlap = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, "cfg_nonovl");
    feed(16'b0110_1101, 7, "nonovl_seq");
    check("nonovl.p", 32'(dut.p), 32'd1);
    check("nonovl.final_cnt", 32'(match_cnt), CNT_ON ? 32'd1 : 32'd0);

    // Stall in match state with w toggling
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "reset2");
    feed(16'b1101, 4, "stall_pre");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, i[0], "stall");
    check("stall.p", 32'(dut.p), 32'd4);
    check("stall.z", 32'(z), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "stall_post");
    check("stall_post.p", 32'(dut.p), 32'd2);

    // Length clamping
    cfg_pattern = 8'h01; cfg_len = 4'd0; cfg_overlap = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, "cfg_len0");
    check("len0.len", 32'(dut.len_r), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, "len0_w1");
    check("len0.z", 32'(z), 32'd1);
    cfg_pattern = 8'hA5; cfg_len = 4'd15; cfg_overlap = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, "cfg_len15");
    check("len15.len", 32'(dut.len_r), 32'd8);
    feed(16'h00A5, 8, "len15_seq");
    check("len15.z", 32'(z), 32'd1);

    // Reset and cfg_load mid-operation with w_valid asserted
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "reset3");
    feed(16'b101, 3, "mid_pre");
    check("mid.p3", 32'(dut.p), 32'd3);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, "mid_reset");
    check("mid_reset.p", 32'(dut.p), 32'd0);
    check("mid_reset.pat", 32'(dut.pattern_r), 32'h0D);
    check("mid_reset.len", 32'(dut.len_r), 32'd4);
    feed(16'b101, 3, "mid_pre2");
    cfg_pattern = 8'h0D; cfg_len = 4'd4; cfg_overlap = 1'b1;
    cycle(1'b0, 1'b1, 1'b1, 1'b1, "mid_load");
    check("mid_load.p", 32'(dut.p), 32'd0);
    feed(16'b1101, 4, "mid_post");

    // len=1 with all ones: match every valid cycle, counter saturates
    cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, "cfg_sat");
    feed(16'b11_1111, 6, "sat");
    check("sat.final_cnt", 32'(match_cnt), CNT_ON ? 32'd3 : 32'd0);

    // Random traffic, overlapping 3-bit pattern 1,1,0
    cfg_pattern = 8'b0000_0011; cfg_len = 4'd3; cfg_overlap = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, "cfg_rand");
    for (int i = 0; i < 60; i++)
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
